fifo_wr_arbiter: RTL

//   Round-robin, burst-aware arbiter that shares the single write port of the async FIFO

---
 rtl/fifo_wr_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin, burst-aware arbiter that shares the write port of an async FIFO
// among NREQ requesters in the write-clock domain. A granted requester keeps
// the port until it sends its packet's last word or reaches MAX_BURST beats.
// Ownership then rotates, starting the search at the requester after the one
// that just finished.
//
// Handshake: a word from requester i is transferred in any cycle where
// o_req_ready[i] is 1. o_req_ready[i] is 1 only when i owns the grant,
// i_req_valid[i] is 1 and i_fifo_full is 0. The word is written to the FIFO
// in the same cycle (o_fifo_w_en=1). A requester that has raised valid must
// keep data and last stable until it sees ready. Requesters that do not own
// the grant never see ready.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  localparam int IDW = $clog2(NREQ),
  localparam int BCW = $clog2(MAX_BURST + 1)
) (
  input  logic                  i_wclk,
  input  logic                  i_wrst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ-1:0]       i_req_last,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic                  i_fifo_full,
  output logic                  o_fifo_w_en,
  output logic [WIDTH-1:0]      o_fifo_wdata,
  output logic [IDW-1:0]        o_grant_id,
  output logic                  o_busy,
  output logic                  o_dbg_state,
  output logic [IDW-1:0]        o_dbg_rr_ptr,
  output logic [BCW-1:0]        o_dbg_beat_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant_id;
  logic [IDW-1:0]   r_rr_ptr;
  logic [BCW-1:0]   r_beat_cnt;
  logic             r_busy;

  logic             w_pick_found;
  logic [IDW-1:0]   w_pick_id;
  logic             w_xfer;
  logic             w_last_beat;

  // Round-robin search: first valid requester after r_rr_ptr, wrapping.
  // The loop runs from the farthest candidate down to the nearest so the
  // nearest valid requester is the one left in w_pick_id.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    v_idx        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      v_idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
      if (i_req_valid[v_idx]) begin
        w_pick_found = 1'b1;
        w_pick_id    = v_idx;
      end
    end
  end

  // Transfer qualification and FIFO-side datapath; zero-cycle accept.
  always_comb begin
    w_xfer       = (r_state == GRANT) && i_req_valid[r_grant_id] && !i_fifo_full;
    w_last_beat  = i_req_last[r_grant_id] || (r_beat_cnt == BCW'(MAX_BURST - 1));
    o_fifo_w_en  = w_xfer;
    o_req_ready  = w_xfer ? (NREQ'(1) << r_grant_id) : '0;
    o_fifo_wdata = i_req_data[r_grant_id*WIDTH +: WIDTH];
  end

  // Arbiter FSM: IDLE spends one cycle choosing an owner, GRANT streams beats
  // until last word or burst cap, stalling without penalty on full or no valid.
  always_ff @(posedge i_wclk) begin
    if (!i_wrst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= IDW'(NREQ - 1);
      r_beat_cnt <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_found) begin
            r_grant_id <= w_pick_id;
            r_beat_cnt <= '0;
            r_state    <= GRANT;
            r_busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (w_xfer) begin
            if (w_last_beat) begin
              // Clearing here keeps the count inside 0..MAX_BURST-1.
              r_beat_cnt <= '0;
              r_rr_ptr   <= r_grant_id;
              r_state    <= IDLE;
              r_busy     <= 1'b0;
            end else begin
              r_beat_cnt <= r_beat_cnt + BCW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered status and debug views of the FSM.
  always_comb begin
    o_grant_id     = r_grant_id;
    o_busy         = r_busy;
    o_dbg_state    = (r_state == GRANT);
    o_dbg_rr_ptr   = r_rr_ptr;
    o_dbg_beat_cnt = r_beat_cnt;
  end

endmodule
